btn_conditioner: RTL and testbench

Front-end conditioner for the vending machine's push-buttons and slide switches, sitting directly upstream of `vending_machine`. Raw board inputs `btn_raw`/`sw_raw` are synchronised and debounced. Each clean button press becomes a single-cycle `btn_pulse`, which drives the vending FSM's `btn` input. Chords (simultaneous or overlapping presses) are rejected, so NEXT+ENTER mashing cannot advance the FSM twice.

---
 rtl/vm_pkg.sv | 18 +
 rtl/debounce_cell.sv | 44 ++++
 rtl/btn_conditioner.sv | 92 +++++++++
 tb/tb_btn_conditioner.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vm_pkg.sv
// Shared definitions for the vending-machine front end: button bit map,
// default widths and the chord arbiter state type.
package vm_pkg;

   localparam int unsigned BTN_NEXT   = 0;
   localparam int unsigned BTN_ENTER  = 1;
   localparam int unsigned BTN_AUX    = 2;
   localparam int unsigned BTN_CHANGE = 3;

   localparam int unsigned N_BTN_DEFAULT = 4;
   localparam int unsigned N_SW_DEFAULT  = 4;

   typedef enum logic {
      ARMED,
      LOCKED
   } arb_state_t;

endpackage

// File: rtl/debounce_cell.sv
// One input path: 2-FF synchroniser followed by a hold-time debouncer that
// only accepts a new level after it persists for DEBOUNCE_CYCLES cycles.
module debounce_cell #(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic          meta;
   logic          s;
   logic          stable;
   logic [CW-1:0] cnt;

   // Any sample equal to stable restarts the count, so the counter can
   // never pass CNT_MAX and needs no wrap protection.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta   <= 1'b0;
         s      <= 1'b0;
         stable <= 1'b0;
         cnt    <= '0;
      end else begin
         meta <= din;
         s    <= meta;
         if (s == stable) begin
            cnt <= '0;
         end else if (cnt == CNT_MAX) begin
            stable <= s;
            cnt    <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign dout = stable;

endmodule

// File: rtl/btn_conditioner.sv
// Debounces buttons and switches, then turns clean button presses into
// single-cycle strobes while locking out chorded presses.
module btn_conditioner
   import vm_pkg::*;
#(
   parameter int unsigned N_BTN           = N_BTN_DEFAULT,
   parameter int unsigned N_SW            = N_SW_DEFAULT,
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] btn_raw,
   input  logic [N_SW-1:0]  sw_raw,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_pulse,
   output logic [N_SW-1:0]  sw_stable,
   output logic             chord_err
);

   for (genvar i = 0; i < int'(N_BTN); i++) begin : g_btn
      debounce_cell #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_cell (
         .clk (clk),
         .rst (rst),
         .din (btn_raw[i]),
         .dout(btn_level[i])
      );
   end

   for (genvar i = 0; i < int'(N_SW); i++) begin : g_sw
      debounce_cell #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_cell (
         .clk (clk),
         .rst (rst),
         .din (sw_raw[i]),
         .dout(sw_stable[i])
      );
   end

   arb_state_t       state;
   arb_state_t       state_next;
   logic [N_BTN-1:0] level_d;
   logic [N_BTN-1:0] rise;
   logic [N_BTN-1:0] others;
   logic [N_BTN-1:0] pulse_next;
   logic             err_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ARMED;
         level_d   <= '0;
         btn_pulse <= '0;
         chord_err <= 1'b0;
      end else begin
         state     <= state_next;
         level_d   <= btn_level;
         btn_pulse <= pulse_next;
         chord_err <= err_next;
      end
   end

   // A press is clean only if it is the sole rising bit and nothing else is
   // already held; anything else is a chord and locks until all released.
   always_comb begin
      state_next = state;
      pulse_next = '0;
      err_next   = 1'b0;
      rise       = btn_level & ~level_d;
      others     = btn_level & ~rise;
      case (state)
         ARMED: begin
            if (rise != '0) begin
               if ($onehot(rise) && (others == '0)) begin
                  pulse_next = rise;
               end else begin
                  err_next   = 1'b1;
                  state_next = LOCKED;
               end
            end
         end
         LOCKED: begin
            if (btn_level == '0) begin
               state_next = ARMED;
            end
         end
         default: state_next = ARMED;
      endcase
   end

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner with a window-based debounce model
// and a rule-based chord arbiter model.
module tb_btn_conditioner;

   localparam int D = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] btn_raw = '0;
   logic [3:0] sw_raw = '0;
   logic [3:0] btn_level;
   logic [3:0] btn_pulse;
   logic [3:0] sw_stable;
   logic       chord_err;

   always #5 clk = ~clk;

   btn_conditioner #(
      .N_BTN(4),
      .N_SW(4),
      .DEBOUNCE_CYCLES(D)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .btn_raw  (btn_raw),
      .sw_raw   (sw_raw),
      .btn_level(btn_level),
      .btn_pulse(btn_pulse),
      .sw_stable(sw_stable),
      .chord_err(chord_err)
   );

   typedef struct packed {
      logic [3:0] lvl;
      logic [3:0] sw;
      logic [3:0] pulse;
      logic       err;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail = 0;
   int   cyc = 0;

   int   pulse_cnt[4] = '{0, 0, 0, 0};
   int   last_pulse_edge[4] = '{0, 0, 0, 0};
   int   err_cnt = 0;
   bit   sw_watch = 0;
   bit   sw_bad = 0;

   function automatic void cmp(string name, int act, int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at edge %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endfunction

   // Reference model: bit i of {sw,btn}; s is the raw value two edges late,
   // and stable takes s once the last D samples of s all disagree with it.
   logic [7:0] m_meta, m_s, m_stable;
   logic [3:0] m_lvl_d, m_pulse;
   logic       m_err, m_locked;
   logic [7:0] s_hist[$];

   task automatic model_edge();
      logic [3:0] lvl, rises;
      bit         all_diff;
      if (rst) begin
         m_meta = '0; m_s = '0; m_stable = '0;
         m_lvl_d = '0; m_pulse = '0; m_err = 1'b0; m_locked = 1'b0;
         s_hist.delete();
      end else begin
         lvl     = m_stable[3:0];
         rises   = lvl & ~m_lvl_d;
         m_pulse = '0;
         m_err   = 1'b0;
         if (!m_locked) begin
            if (rises != 0) begin
               if ($countones(rises) == 1 && (lvl & ~rises) == 0) m_pulse = rises;
               else begin
                  m_err    = 1'b1;
                  m_locked = 1'b1;
               end
            end
         end else if (lvl == 0) begin
            m_locked = 1'b0;
         end
         m_lvl_d = lvl;
         s_hist.push_back(m_s);
         if (s_hist.size() > D) void'(s_hist.pop_front());
         if (s_hist.size() == D) begin
            for (int i = 0; i < 8; i++) begin
               all_diff = 1;
               for (int j = 0; j < D; j++)
                  if (s_hist[j][i] == m_stable[i]) all_diff = 0;
               if (all_diff) m_stable[i] = ~m_stable[i];
            end
         end
         m_s    = m_meta;
         m_meta = {sw_raw, btn_raw};
      end
   endtask

   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      cyc++;
      model_edge();
      e.lvl   = m_stable[3:0];
      e.sw    = m_stable[7:4];
      e.pulse = m_pulse;
      e.err   = m_err;
      exp_q.push_back(e);
   endtask

   task automatic hold(input logic [3:0] b, input logic [3:0] s, input int n);
      btn_raw = b;
      sw_raw  = s;
      repeat (n) tick();
   endtask

   task automatic sync_mon();
      @(negedge clk);
      #1;
   endtask

   // Monitor: the DUT presents all outputs every cycle.
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         cmp("btn_level", int'(btn_level), int'(e.lvl));
         cmp("sw_stable", int'(sw_stable), int'(e.sw));
         cmp("btn_pulse", int'(btn_pulse), int'(e.pulse));
         cmp("chord_err", int'(chord_err), int'(e.err));
         for (int i = 0; i < 4; i++)
            if (btn_pulse[i] === 1'b1) begin
               pulse_cnt[i]++;
               last_pulse_edge[i] = cyc;
            end
         if (chord_err === 1'b1) err_cnt++;
         if (sw_watch && sw_stable !== 4'b0000 && sw_stable !== 4'b0101) sw_bad = 1;
      end
   end

   initial begin
      int p0, p1, p2, p3, e0, start, tot;
      logic [3:0] b, s;

      hold(4'b0000, 4'b0000, 3);
      rst = 1'b0;
      hold(4'b0000, 4'b0000, 4);

      // clean press
      sync_mon(); p0 = pulse_cnt[0]; e0 = err_cnt;
      start = cyc + 1;
      hold(4'b0001, 4'b0000, 10);
      hold(4'b0000, 4'b0000, 10);
      sync_mon();
      cmp("clean_count", pulse_cnt[0] - p0, 1);
      cmp("clean_latency", last_pulse_edge[0] - start, 6);
      cmp("clean_no_err", err_cnt - e0, 0);

      // bounce then hold
      p1 = pulse_cnt[1];
      hold(4'b0010, 4'b0000, 1);
      hold(4'b0000, 4'b0000, 1);
      hold(4'b0010, 4'b0000, 1);
      hold(4'b0000, 4'b0000, 1);
      start = cyc + 1;
      hold(4'b0010, 4'b0000, 10);
      hold(4'b0000, 4'b0000, 10);
      sync_mon();
      cmp("bounce_count", pulse_cnt[1] - p1, 1);
      cmp("bounce_latency", last_pulse_edge[1] - start, 6);

      // 3-cycle glitch
      p2 = pulse_cnt[2];
      hold(4'b0100, 4'b0000, 3);
      hold(4'b0000, 4'b0000, 10);
      sync_mon();
      cmp("glitch_count", pulse_cnt[2] - p2, 0);

      // simultaneous chord, then a normal press
      tot = pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3];
      e0 = err_cnt;
      hold(4'b0011, 4'b0000, 10);
      hold(4'b0000, 4'b0000, 10);
      sync_mon();
      cmp("chord_err_count", err_cnt - e0, 1);
      cmp("chord_no_pulse", pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3] - tot, 0);
      p0 = pulse_cnt[0];
      start = cyc + 1;
      hold(4'b0001, 4'b0000, 10);
      hold(4'b0000, 4'b0000, 10);
      sync_mon();
      cmp("after_chord_count", pulse_cnt[0] - p0, 1);
      cmp("after_chord_latency", last_pulse_edge[0] - start, 6);

      // overlap chord, partial release and re-press while locked
      p0 = pulse_cnt[0]; p3 = pulse_cnt[3]; e0 = err_cnt;
      hold(4'b0001, 4'b0000, 10);
      hold(4'b1001, 4'b0000, 10);
      hold(4'b0001, 4'b0000, 10);
      hold(4'b1001, 4'b0000, 10);
      hold(4'b0000, 4'b0000, 12);
      sync_mon();
      cmp("overlap_pulse0", pulse_cnt[0] - p0, 1);
      cmp("overlap_pulse3", pulse_cnt[3] - p3, 0);
      cmp("overlap_err", err_cnt - e0, 1);
      p3 = pulse_cnt[3];
      start = cyc + 1;
      hold(4'b1000, 4'b0000, 10);
      hold(4'b0000, 4'b0000, 10);
      sync_mon();
      cmp("rearmed_count", pulse_cnt[3] - p3, 1);
      cmp("rearmed_latency", last_pulse_edge[3] - start, 6);

      // switches: short blip on bit 2, then 0101 together
      tot = pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3];
      sw_watch = 1;
      hold(4'b0000, 4'b0100, 2);
      hold(4'b0000, 4'b0000, 2);
      hold(4'b0000, 4'b0101, 10);
      sync_mon();
      sw_watch = 0;
      cmp("sw_no_intermediate", int'(sw_bad), 0);
      cmp("sw_final", int'(sw_stable), 5);
      cmp("sw_no_pulse", pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3] - tot, 0);
      hold(4'b0000, 4'b0000, 10);

      // reset while a held button is already accepted
      p3 = pulse_cnt[3];
      hold(4'b1000, 4'b0000, 8);
      rst = 1'b1;
      hold(4'b1000, 4'b0000, 2);
      sync_mon();
      cmp("rst_level_clear", int'(btn_level), 0);
      rst = 1'b0;
      start = cyc + 1;
      hold(4'b1000, 4'b0000, 10);
      hold(4'b0000, 4'b0000, 10);
      sync_mon();
      cmp("rst_press_count", pulse_cnt[3] - p3, 2);
      cmp("rst_press_latency", last_pulse_edge[3] - start, 6);

      // randomized traffic
      for (int seg = 0; seg < 250; seg++) begin
         int r;
         r = int'($urandom_range(0, 99));
         if (r < 45) b = 4'b0000;
         else if (r < 85) b = 4'(1 << $urandom_range(0, 3));
         else b = 4'($urandom_range(0, 15));
         s = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 39) == 0) begin
            rst = 1'b1;
            hold(b, s, int'($urandom_range(1, 2)));
            rst = 1'b0;
         end else begin
            hold(b, s, int'($urandom_range(1, 14)));
         end
      end
      hold(4'b0000, 4'b0000, 12);
      sync_mon();
      cmp("queue_drained", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
